mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 8:1 bit-select path between 8 requesters.
//  Picks one requester, drives the 3-bit select and a one-hot grant, and holds them until release.
//  Routes the selected input bit to a single output.
//  Sits between the requesting channels and any downstream single-bit consumer.
// PARAMETERS
//  N_REQ     8   number of requesters; fixed at 8, must match the 3-bit select
//  HOLD_MAX  15  max cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined
// PORTS
//  clk       in   1  rising-edge clock
//  rst_n     in   1  asynchronous active-low reset
//  req       in   8  request lines, one per channel; level, held until granted
//  done      in   1  release strobe from the currently granted channel
//  data_in   in   8  per-channel data bits
//  sel       out  3  registered select index of the granted channel
//  gnt       out  8  registered one-hot grant; 0 when idle
//  busy      out  1  registered; 1 while a grant is active
//  data_out  out  1  data_in[sel] when busy, else 0 (combinational from registers)
//  timeout   out  1  1-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  - Reset (async assert, sync deassert by clk): state=IDLE, sel=0, gnt=0, busy=0, ptr=0,
//    timeout=0, hold counter=0. Reset mid-grant drops gnt immediately.
//  - FSM states: IDLE, BUSY.
//  - IDLE: if |req, pick the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
//    Next edge: sel=idx, gnt=1<<idx, busy=1, go BUSY. Latency is 1 clk from req to gnt.
//  - IDLE with req==0: all outputs hold their idle values.
//  - BUSY release condition: done==1, or req[sel]==0 (requester withdrew).
//    Next edge: gnt=0, busy=0, ptr=(sel+1) mod 8 (7 wraps to 0), go IDLE. sel keeps its last value.
//  - One mandatory IDLE cycle between consecutive grants; no back-to-back grant.
//  - Requests to other channels during BUSY are ignored until IDLE; nothing is queued or latched.
//  - done while IDLE: ignored.
//  - Withdrawal and done in the same cycle: a single release.
//  - Fairness: a continuously requesting channel is granted within 8 grants.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - 4-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
//   - When count==HOLD_MAX with no release, next edge does a forced release (same as a
//     normal release) and timeout=1 for exactly one cycle.
//   - If done coincides with the timeout cycle: normal release, timeout stays 0.
//  ARB_TIMEOUT_EN undefined: no counter is built, timeout=0, and a grant is held indefinitely.
// STRUCTURE
//  - Package mux_arb_pkg:
//    - localparams N_REQ=8, SEL_W=3
//    - typedef enum {IDLE, BUSY} arb_state_t
//    - typedef logic [SEL_W-1:0] sel_t
//  - Sub-module rr_pick (combinational): inputs req[7:0], ptr[2:0]; outputs any, idx[2:0].
//    Rotates req by ptr, applies a priority encoder, then adds ptr back mod 8.
//  - Top level holds the FSM, the ptr/sel/gnt registers, the data_out select and the
//    optional counter.
// TESTING
//  1. Reset: rst_n=0 mid-grant (gnt=8'h04) -> gnt=0, busy=0, sel=0 asynchronously.
//     After release, req=8'h01 -> gnt=8'h01 one edge later.
//  2. Round-robin: req=8'hFF held, done pulsed each grant ->
//     sel sequence 0,1,2,...,7,0 with an IDLE cycle between grants.
//  3. Wrap and skip: ptr=6, req=8'h21 -> sel=0 first, then sel=5.
//  4. Withdrawal: grant ch3, drop req[3] without done -> busy=0 next edge, ptr=4.
//  5. Datapath: grant ch2 with data_in=8'h04 -> data_out=1; data_in=8'hFB -> data_out=0;
//     idle -> data_out=0.
//  6. ARB_TIMEOUT_EN: hold req[1] with no done -> forced release after HOLD_MAX+1 BUSY
//     cycles and timeout high 1 cycle. Same bench without the macro -> gnt held, timeout=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the round-robin 8:1 bit-select arbiter.
// Imported by rr_pick and mux_rr_arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE,
      BUSY
   } arb_state_t;

   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning from ptr.
// Ports: req[7:0], ptr[2:0] in; any, idx[2:0] out.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  sel_t             ptr,
   output logic             any,
   output sel_t             idx
);

   logic [N_REQ-1:0] rot;
   sel_t             off;

   // rot[i] is the channel i positions past ptr
   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[sel_t'(sel_t'(i) + ptr)];
      end
   end

   // lowest set bit of the rotated vector wins
   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = sel_t'(i);
      end
   end

   assign any = |req;
   assign idx = off + ptr;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning one 8:1 bit-select path; holds grant until release.
// Ports: clk, rst_n, req[7:0], done, data_in[7:0] in; sel[2:0], gnt[7:0],
// busy, data_out, timeout out. Optional forced release: ARB_TIMEOUT_EN.
module mux_rr_arbiter
   import mux_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   input  logic [N_REQ-1:0] data_in,
   output sel_t             sel,
   output logic [N_REQ-1:0] gnt,
   output logic             busy,
   output logic             data_out,
   output logic             timeout
);

`ifdef ARB_TIMEOUT_EN
   parameter logic [3:0] HOLD_MAX = 4'd15;
`endif

   arb_state_t       state_q, state_d;
   sel_t             sel_d;
   sel_t             ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_d;
   logic             busy_d;
   logic             pick_any;
   sel_t             pick_idx;
   logic             release_ok;
   logic             force_rel;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign release_ok = done | ~req[sel];

`ifdef ARB_TIMEOUT_EN
   logic [3:0] cnt_q, cnt_d;
   logic       tmo_q, tmo_d;

   assign force_rel = (cnt_q == HOLD_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      tmo_d = 1'b0;
      unique case (state_q)
         IDLE: cnt_d = '0;
         BUSY: begin
            cnt_d = cnt_q + 4'd1;
            // a real release in the same cycle suppresses the pulse
            tmo_d = force_rel & ~release_ok;
         end
         default: cnt_d = '0;
      endcase
   end

   assign timeout = tmo_q;
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel;
      gnt_d   = gnt;
      busy_d  = busy;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               sel_d           = pick_idx;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               busy_d          = 1'b1;
               state_d         = BUSY;
            end
         end
         BUSY: begin
            // sel is left as-is so the last owner stays visible
            if (release_ok | force_rel) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               ptr_d   = sel + sel_t'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel     <= '0;
         gnt     <= '0;
         busy    <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sel     <= sel_d;
         gnt     <= gnt_d;
         busy    <= busy_d;
         ptr_q   <= ptr_d;
      end
   end

   assign data_out = busy & data_in[sel];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter with a behavioural round-robin model.
// Define ARB_TIMEOUT_EN to check the forced-release build.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] data_in;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       busy;
   logic       data_out;
   logic       timeout;

   mux_rr_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .done     (done),
      .data_in  (data_in),
      .sel      (sel),
      .gnt      (gnt),
      .busy     (busy),
      .data_out (data_out),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int HOLD_CYCLES = 16;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
      logic       dout;
      logic       tmo;
   } exp_t;

   exp_t q[$];

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   bit m_busy;
   int m_sel;
   int m_ptr;
   int m_held;
   bit m_tmo;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("gnt", gnt, e.gnt);
         chk("sel", 8'(sel), 8'(e.sel));
         chk("busy", 8'(busy), 8'(e.busy));
         chk("data_out", 8'(data_out), 8'(e.dout));
         chk("timeout", 8'(timeout), 8'(e.tmo));
      end
   end

   task automatic model_reset();
      m_busy = 0;
      m_sel  = 0;
      m_ptr  = 0;
      m_held = 0;
      m_tmo  = 0;
   endtask

   // what the outputs should be after the coming rising edge
   task automatic model_step(input logic [7:0] r, input logic d);
      bit rel;
      m_tmo = 0;
      if (!m_busy) begin
         if (r != 0) begin
            for (int k = 0; k < 8; k++) begin
               int c;
               c = (m_ptr + k) % 8;
               if (r[c]) begin
                  m_sel  = c;
                  m_busy = 1;
                  m_held = 0;
                  break;
               end
            end
         end
      end else begin
         m_held++;
         rel = d || !r[m_sel];
         if (rel) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 8;
         end else if (TMO_EN && m_held == HOLD_CYCLES) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 8;
            m_tmo  = 1;
         end
      end
   endtask

   task automatic step(input logic [7:0] r, input logic d,
                       input logic [7:0] di);
      exp_t e;
      @(negedge clk);
      req     = r;
      done    = d;
      data_in = di;
      model_step(r, d);
      e.gnt  = m_busy ? (8'h01 << m_sel) : 8'h00;
      e.sel  = 3'(m_sel);
      e.busy = m_busy;
      e.dout = m_busy ? di[m_sel] : 1'b0;
      e.tmo  = m_tmo;
      q.push_back(e);
   endtask

   // async assert mid-cycle, checked before any clock edge
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", gnt, 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
      chk("rst_sel", 8'(sel), 8'h00);
      chk("rst_timeout", 8'(timeout), 8'h00);
      req     = '0;
      done    = 1'b0;
      data_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] r;
      rst_n   = 1'b1;
      req     = '0;
      done    = 1'b0;
      data_in = '0;
      model_reset();
      do_reset();

      // idle hold
      step(8'h00, 1'b0, 8'hFF);
      step(8'h00, 1'b1, 8'hFF);

      // datapath on channel 2
      step(8'h04, 1'b0, 8'h04);
      step(8'h04, 1'b0, 8'hFB);
      step(8'h04, 1'b1, 8'hFF);
      step(8'h00, 1'b0, 8'hFF);

      // reset mid-grant, then fresh grant to channel 0
      step(8'h04, 1'b0, 8'h00);
      step(8'h04, 1'b0, 8'h00);
      do_reset();
      step(8'h01, 1'b0, 8'h01);
      step(8'h01, 1'b1, 8'h01);
      step(8'h00, 1'b0, 8'h00);

      // full rotation with done held high
      for (int i = 0; i < 18; i++) step(8'hFF, 1'b1, 8'hAA);
      step(8'h00, 1'b0, 8'h00);

      // leave ptr at 6, then wrap past 7
      step(8'h20, 1'b0, 8'h00);
      step(8'h20, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) step(8'h21, 1'b1, 8'h21);
      step(8'h00, 1'b0, 8'h00);

      // withdrawal without done
      step(8'h08, 1'b0, 8'h08);
      step(8'h00, 1'b0, 8'h08);
      step(8'hFF, 1'b0, 8'h10);
      step(8'hFF, 1'b1, 8'h10);
      step(8'h00, 1'b0, 8'h00);

      // long hold on channel 1
      for (int i = 0; i < 22; i++) step(8'h02, 1'b0, 8'h02);
      step(8'h02, 1'b1, 8'h02);
      step(8'h00, 1'b0, 8'h00);

      // done on the 16th busy cycle
      for (int i = 0; i < 16; i++) step(8'h02, 1'b0, 8'h02);
      step(8'h02, 1'b1, 8'h02);
      step(8'h00, 1'b0, 8'h00);

      // random traffic with sticky requests
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         end
         step(r, ($urandom_range(0, 5) == 0), 8'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
